muldiv_seq: RTL

Iterative multi-cycle sequencer for the RV32M multiply/divide operations, removing the 64-bit combinational multiplier from the execute-stage critical path. It sits beside the execute-stage ALU, takes one operation through a valid/ready handshake, and runs a 32-step shift-add (multiply) or restoring shift-subtract (divide) datapath. The pipeline stalls while `in_ready` is low and captures `result` on `out_valid`.

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_sign_fix.sv | 18 +
 rtl/muldiv_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and helpers for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam int MULDIV_STEPS = 32;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_returns_hi(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic op_sign1(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_sign2(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Conditional two's-complement negate of a WIDTH-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix #(
    parameter int WIDTH = 64
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_neg ? (~i_value + WIDTH'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide sequencer, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int            c_cnt_w     = $clog2(MULDIV_STEPS);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(MULDIV_STEPS - 1);
    localparam logic [XLEN-1:0]    c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e       r_state;
    muldiv_op_e          r_op;
    logic                r_s1;
    logic                r_s2;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic                r_special;
    logic [XLEN-1:0]     r_special_res;
    logic [XLEN-1:0]     r_result;

    muldiv_op_e          w_op;
    logic                w_accept;
    logic                w_s1;
    logic                w_s2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op       = muldiv_op_e'(op);
        w_accept   = (r_state == IDLE) && in_valid && !flush;
        w_s1       = operand1[XLEN-1] & op_sign1(w_op);
        w_s2       = operand2[XLEN-1] & op_sign2(w_op);
        w_div_zero = op_is_div(w_op) && (operand2 == '0);
        w_div_ovf  = (w_op inside {OP_DIV, OP_REM}) &&
                     (operand1 == c_int_min) && (operand2 == '1);
        w_special  = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_special_res = op_is_rem(w_op) ? operand1 : '1;
        end else begin
            w_special_res = op_is_rem(w_op) ? '0 : c_int_min;
        end
    end

    muldiv_sign_fix #(.WIDTH(XLEN)) u_mag1 (
        .i_neg   (w_s1),
        .i_value (operand1),
        .o_value (w_mag1)
    );

    muldiv_sign_fix #(.WIDTH(XLEN)) u_mag2 (
        .i_neg   (w_s2),
        .i_value (operand2),
        .o_value (w_mag2)
    );

    // ------------------------------------------------------------------
    // One iteration step. r_acc holds {high, low}: for multiply the low
    // half is the multiplier being shifted out as the product shifts in;
    // for divide it is {partial remainder, dividend/quotient}.
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_step_next;

    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                              : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};

        w_div_shift = r_acc[2*XLEN-1:XLEN-1];
        w_div_ge    = w_div_shift >= {1'b0, r_opnd};
        // When the subtraction succeeds the difference always fits in XLEN bits.
        w_div_sub   = w_div_shift[XLEN-1:0] - r_opnd;
        w_div_next  = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                               : {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

        w_step_next = op_is_div(r_op) ? w_div_next : w_mul_next;
    end

    // ------------------------------------------------------------------
    // Result sign correction
    // ------------------------------------------------------------------
    logic              w_fix_neg;
    logic [2*XLEN-1:0] w_fix_in;
    logic [2*XLEN-1:0] w_fix_out;
    logic [XLEN-1:0]   w_done_res;

    always_comb begin
        if (!op_is_div(r_op)) begin
            w_fix_in  = r_acc;
            w_fix_neg = r_s1 ^ r_s2;
        end else if (op_is_rem(r_op)) begin
            w_fix_in  = {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]};
            w_fix_neg = r_s1;
        end else begin
            w_fix_in  = {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
            w_fix_neg = r_s1 ^ r_s2;
        end
    end

    muldiv_sign_fix #(.WIDTH(2*XLEN)) u_res_fix (
        .i_neg   (w_fix_neg),
        .i_value (w_fix_in),
        .o_value (w_fix_out)
    );

    always_comb begin
        if (r_special) begin
            w_done_res = r_special_res;
        end else if (op_returns_hi(r_op)) begin
            w_done_res = w_fix_out[2*XLEN-1:XLEN];
        end else begin
            w_done_res = w_fix_out[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op          <= OP_MUL;
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_opnd        <= '0;
            r_special     <= 1'b0;
            r_special_res <= '0;
            r_result      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op          <= w_op;
                        r_s1          <= w_s1;
                        r_s2          <= w_s2;
                        r_cnt         <= '0;
                        r_special     <= w_special;
                        r_special_res <= w_special_res;
                        if (op_is_div(w_op)) begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag1};
                            r_opnd <= w_mag2;
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, w_mag2};
                            r_opnd <= w_mag1;
                        end
                        r_state <= w_special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_step_next;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last_step) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!flush) begin
                        r_result <= w_done_res;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The pulse and its data are presented in the DONE cycle itself so the
    // pipeline can capture on out_valid; a flush hides both.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE) && !flush;
    assign result    = out_valid ? w_done_res : r_result;

endmodule
`default_nettype wire
